// File: rtl/string_hw_pkg.sv
// Shared definitions for the String HW accelerator and its copy master.
package string_hw_pkg;

  // Copy master FSM states
  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StDone
  } copy_state_t;

  // Byte stride of one data word
  function automatic int unsigned word_bytes(int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned WORD_BYTES     = word_bytes(DEFAULT_DATA_W);

  // Avalon word offsets of the accelerator slave registers
  localparam logic [1:0] REG_A       = 2'd0;
  localparam logic [1:0] REG_B       = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_RESULT  = 2'd3;

endpackage

// File: rtl/string_copy_master.sv
// Avalon-MM master that copies a block of words from a source region to a
// fixed (FIFO port) or incrementing destination address. One read is
// outstanding at a time; each word is read, captured, then written.
// Optional build macro STRING_COPY_CHECKSUM_EN adds a running word sum
// output `checksum`.
module string_copy_master
  import string_hw_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              dst_inc,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
`ifdef STRING_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam logic [ADDR_W-1:0] Stride = ADDR_W'(word_bytes(DATA_W));

  copy_state_t       state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic              dst_inc_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic              avm_read_q;
  logic              avm_write_q;
  logic [DATA_W-1:0] avm_writedata_q;
  logic              busy_q;
  logic              done_q;

  // Next-address values used when a write is accepted
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;

  // Address advance; wraps modulo 2^ADDR_W
  always_comb begin
    src_next = src_q + Stride;
    dst_next = dst_inc_q ? (dst_q + Stride) : dst_q;
  end

  // Copy FSM with all bus and status outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      src_q           <= '0;
      dst_q           <= '0;
      dst_inc_q       <= 1'b0;
      remaining_q     <= '0;
      avm_address_q   <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            src_q       <= src_addr;
            dst_q       <= dst_addr;
            dst_inc_q   <= dst_inc;
            remaining_q <= word_count;
            if (word_count == '0) begin
              // Empty transfer: report completion without bus traffic
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q       <= StRdReq;
              avm_read_q    <= 1'b1;
              avm_address_q <= src_addr;
              busy_q        <= 1'b1;
            end
          end
        end
        StRdReq: begin
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            state_q    <= StRdWait;
          end
        end
        StRdWait: begin
          if (avm_readdatavalid) begin
            avm_writedata_q <= avm_readdata;
            avm_address_q   <= dst_q;
            avm_write_q     <= 1'b1;
            state_q         <= StWrReq;
          end
        end
        StWrReq: begin
          if (!avm_waitrequest) begin
            avm_write_q <= 1'b0;
            remaining_q <= remaining_q - CNT_W'(1);
            src_q       <= src_next;
            dst_q       <= dst_next;
            if (remaining_q == CNT_W'(1)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q       <= StRdReq;
              avm_read_q    <= 1'b1;
              avm_address_q <= src_next;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef STRING_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  // Running sum of written words; cleared when a new transfer is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (state_q == StIdle && start) begin
      checksum_q <= '0;
    end else if (state_q == StWrReq && !avm_waitrequest) begin
      checksum_q <= checksum_q + avm_writedata_q;
    end
  end

  assign checksum = checksum_q;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign avm_address   = avm_address_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_string_copy_master.sv
// Scoreboard bench for string_copy_master: stimulus pushes expected bus
// events, a monitor pops and compares each accepted read, write and done.
module tb_string_copy_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic        dst_inc;
  logic [4:0]  word_count;
  logic        busy;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
`ifdef STRING_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  string_copy_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .CNT_W (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .dst_inc          (dst_inc),
    .word_count       (word_count),
    .busy             (busy),
    .done             (done),
`ifdef STRING_COPY_CHECKSUM_EN
    .checksum         (checksum),
`endif
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest  (avm_waitrequest)
  );

  always #5 clk = ~clk;

  localparam int KRead  = 0;
  localparam int KWrite = 1;
  localparam int KDone  = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  start_cyc = 0;

  // Slave controls
  int          wr_stall     = 0;
  int          stall_cnt    = 0;
  bit          rd_pending   = 1'b0;
  logic [31:0] rd_addr      = '0;
  bit          suppress_rdv = 1'b0;
  bit          stray_req    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input int c);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h0000_0011;
      32'h0000_1004: return 32'h0000_0022;
      32'h0000_1008: return 32'h0000_0033;
      32'hFFFF_FFFC: return 32'hDEAD_BEEF;
      32'h0000_0000: return 32'h0123_4567;
      32'h0000_4000: return 32'hCAFE_F00D;
      32'h0000_4004: return 32'h0BAD_C0DE;
      default:       return 32'h0;
    endcase
  endfunction

  // Avalon slave model: drives its responses at the falling edge
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_pending        = 1'b0;
        stall_cnt         = 0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        if (rd_pending && !suppress_rdv) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = mem_word(rd_addr);
        end
        rd_pending = 1'b0;
        if (stray_req) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = 32'hBAD0_BAD0;
          stray_req         = 1'b0;
        end
        avm_waitrequest = 1'b0;
        if (avm_write && stall_cnt < wr_stall) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end
        if (avm_read && !avm_waitrequest) begin
          rd_pending = 1'b1;
          rd_addr    = avm_address;
        end
        if (avm_write && !avm_waitrequest) stall_cnt = 0;
      end
    end
  end

  task automatic observe(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h, required none", kind,
               addr, data);
    end else begin
      e = exp_q.pop_front();
      check32("ev_kind", 32'(kind), 32'(e.kind));
      check32("ev_addr", addr, e.addr);
      check32("ev_data", data, e.data);
      if (e.cyc >= 0) check32("done_cycle", 32'(c), 32'(e.cyc));
    end
  endtask

  // Monitor: samples away from both edges and scores each bus event
  logic        prev_wr_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic [31:0] cs_now;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_wr_stall = 1'b0;
      end else begin
        if (avm_read && avm_write) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_wr_overlap: got read=1 write=1, required not both");
        end
        if (prev_wr_stall) begin
          check32("wr_hold_valid", 32'(avm_write), 32'd1);
          check32("wr_hold_addr", avm_address, prev_addr);
          check32("wr_hold_data", avm_writedata, prev_data);
        end
        prev_wr_stall = avm_write && avm_waitrequest;
        prev_addr     = avm_address;
        prev_data     = avm_writedata;
        if (avm_read && !avm_waitrequest) observe(KRead, avm_address, 32'h0, -1);
        if (avm_write && !avm_waitrequest) observe(KWrite, avm_address, avm_writedata, -1);
        if (done) begin
`ifdef STRING_COPY_CHECKSUM_EN
          cs_now = checksum;
`else
          cs_now = 32'h0;
`endif
          observe(KDone, 32'h0, cs_now, cyc - start_cyc);
        end
      end
    end
  end

  function automatic logic [31:0] exp_cs(input logic [31:0] v);
`ifdef STRING_COPY_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check32({tag, "_read"}, 32'(avm_read), 32'd0);
    check32({tag, "_write"}, 32'(avm_write), 32'd0);
    check32({tag, "_addr"}, avm_address, 32'h0);
    check32({tag, "_wdata"}, avm_writedata, 32'h0);
    check32({tag, "_busy"}, 32'(busy), 32'd0);
    check32({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Issues a one-cycle start; returns at the falling edge of cycle 1
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic inc,
                          input logic [4:0] n);
    @(negedge clk);
    src_addr   = s;
    dst_addr   = d;
    dst_inc    = inc;
    word_count = n;
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d events outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    dst_inc    = 1'b0;
    word_count = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed destination, three words, zero-wait slave
    push_ev(KRead, 32'h1000, 0, -1);
    push_ev(KWrite, 32'h2000, 32'h11, -1);
    push_ev(KRead, 32'h1004, 0, -1);
    push_ev(KWrite, 32'h2000, 32'h22, -1);
    push_ev(KRead, 32'h1008, 0, -1);
    push_ev(KWrite, 32'h2000, 32'h33, -1);
    push_ev(KDone, 0, exp_cs(32'h66), 10);
    run_copy(32'h1000, 32'h2000, 1'b0, 5'd3);
    #1;
    check32("t1_cyc1_read", 32'(avm_read), 32'd1);
    check32("t1_cyc1_busy", 32'(busy), 32'd1);
    drain("t1", 60);

    // Zero-length transfer: done in cycle 1, no bus traffic
    push_ev(KDone, 0, exp_cs(32'h0), 1);
    run_copy(32'h1000, 32'h2000, 1'b0, 5'd0);
    #1;
    check32("t2_cyc1_busy", 32'(busy), 32'd0);
    check32("t2_cyc1_read", 32'(avm_read), 32'd0);
    drain("t2", 20);

    // Incrementing destination with source address wrap
    push_ev(KRead, 32'hFFFF_FFFC, 0, -1);
    push_ev(KWrite, 32'h3000, 32'hDEAD_BEEF, -1);
    push_ev(KRead, 32'h0000_0000, 0, -1);
    push_ev(KWrite, 32'h3004, 32'h0123_4567, -1);
    push_ev(KDone, 0, exp_cs(32'hDFD1_0456), 7);
    run_copy(32'hFFFF_FFFC, 32'h3000, 1'b1, 5'd2);
    drain("t3", 60);

    // Four stall cycles per write, plus an ignored mid-transfer start
    wr_stall = 4;
    push_ev(KRead, 32'h4000, 0, -1);
    push_ev(KWrite, 32'h5000, 32'hCAFE_F00D, -1);
    push_ev(KRead, 32'h4004, 0, -1);
    push_ev(KWrite, 32'h5004, 32'h0BAD_C0DE, -1);
    push_ev(KDone, 0, exp_cs(32'hD6AC_B0EB), 15);
    run_copy(32'h4000, 32'h5000, 1'b1, 5'd2);
    repeat (4) @(negedge clk);
    src_addr   = 32'h9000;
    dst_addr   = 32'h9900;
    word_count = 5'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("t4", 80);
    wr_stall = 0;

    // Reset while waiting for read data, then a stray response
    suppress_rdv = 1'b1;
    push_ev(KRead, 32'h1000, 0, -1);
    run_copy(32'h1000, 32'h2000, 1'b0, 5'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("t5_in_reset");
    @(negedge clk);
    reset        = 1'b0;
    suppress_rdv = 1'b0;
    stray_req    = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check_idle_outputs("t5_after");
    drain("t5", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
